// File: rtl/fu_load_if.sv
// rtl/fu_load_if.sv - shared packet types and the load unit's bus interface
package sys_defs;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LS_LB  = 3'd0,
    LS_LH  = 3'd1,
    LS_LW  = 3'd2,
    LS_LBU = 3'd4,
    LS_LHU = 3'd5
  } LS_TYPE;

  typedef struct packed {
    LS_TYPE ls;
  } DEC_FU_OPCODE;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] r1_value;
    DEC_FU_OPCODE    dec_fu_opcode;
    logic [5:0]      dispatch_allocated_prs;
    logic [4:0]      rob_entry;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] dest_value;
    logic [5:0]      dest_pr;
    logic [4:0]      rob_entry;
    logic            take_branch;
    logic [XLEN-1:0] target_pc;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } LOAD_SQ_PACKET;

  typedef struct packed {
    logic            stall;
    logic [3:0]      usebytes;
    logic [XLEN-1:0] data;
  } SQ_LOAD_PACKET;
endpackage

// Issue, complete, store-queue and data-cache signals of the load unit
interface fu_load_if;
  import sys_defs::*;

  logic              bs_hazard;
  ISSUE_FU_PACKET    bs_in_pkt;
  logic              rsb_fu_ready;
  logic              fum_complete_req;
  FU_COMPLETE_PACKET bs_out_pkt;
  LOAD_SQ_PACKET     ld_sq_request;
  SQ_LOAD_PACKET     ld_sq_response;
  logic [XLEN-1:0]   addr;
  logic              ld_cache_read_enable;
  logic [XLEN-1:0]   ld_cache_data_in;
  logic              exs_dcache_hit_flags;
  logic              broadcast_en;
  logic [XLEN-1:0]   exs_dcache_brdcast_data;

  // master is the load unit itself
  modport master (
    input  bs_hazard, bs_in_pkt, ld_sq_response, ld_cache_data_in,
           exs_dcache_hit_flags, broadcast_en, exs_dcache_brdcast_data,
    output rsb_fu_ready, fum_complete_req, bs_out_pkt, ld_sq_request,
           addr, ld_cache_read_enable
  );

  // slave is the surrounding pipeline, store queue and cache
  modport slave (
    output bs_hazard, bs_in_pkt, ld_sq_response, ld_cache_data_in,
           exs_dcache_hit_flags, broadcast_en, exs_dcache_brdcast_data,
    input  rsb_fu_ready, fum_complete_req, bs_out_pkt, ld_sq_request,
           addr, ld_cache_read_enable
  );
endinterface

// File: rtl/fu_load.sv
// rtl/fu_load.sv - non-pipelined load unit: address, forwarding merge, extract, complete
module fu_load
  import sys_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  fu_load_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  LS_TYPE      ls_q, ls_d;
  logic [5:0]  pr_q, pr_d;
  logic [4:0]  rob_q, rob_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  out_pr_q, out_pr_d;
  logic [4:0]  out_rob_q, out_rob_d;

  logic [31:0] cache_word;
  logic [31:0] merged_word;
  logic        word_avail;

  // Pick the addressed byte/half and extend it according to the load type
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input LS_TYPE ls);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (ls)
      LS_LB:   extract = {{24{b[7]}}, b};
      LS_LBU:  extract = {24'd0, b};
      LS_LH:   extract = {{16{h[15]}}, h};
      LS_LHU:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Merge forwarded store bytes over the cache word; a hit outranks a refill broadcast
  always_comb begin
    cache_word  = bus.exs_dcache_hit_flags ? bus.ld_cache_data_in : bus.exs_dcache_brdcast_data;
    merged_word = cache_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.ld_sq_response.usebytes[i]) merged_word[8*i +: 8] = bus.ld_sq_response.data[8*i +: 8];
    end
    word_avail = (bus.ld_sq_response.usebytes == 4'hF) || bus.exs_dcache_hit_flags
                 || bus.broadcast_en;
  end

  // Next-state and register updates for issue, memory access and completion
  always_comb begin
    state_d   = state_q;
    ea_d      = ea_q;
    ls_d      = ls_q;
    pr_d      = pr_q;
    rob_d     = rob_q;
    result_d  = result_q;
    out_pr_d  = out_pr_q;
    out_rob_d = out_rob_q;
    case (state_q)
      S_IDLE: begin
        if (bus.bs_in_pkt.valid) begin
          ea_d    = bus.bs_in_pkt.r1_value
                    + {{20{bus.bs_in_pkt.inst[31]}}, bus.bs_in_pkt.inst[31:20]};
          ls_d    = bus.bs_in_pkt.dec_fu_opcode.ls;
          pr_d    = bus.bs_in_pkt.dispatch_allocated_prs;
          rob_d   = bus.bs_in_pkt.rob_entry;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (word_avail && !bus.ld_sq_response.stall) begin
          result_d  = extract(merged_word, ea_q[1:0], ls_q);
          out_pr_d  = pr_q;
          out_rob_d = rob_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.bs_hazard) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ea_q      <= '0;
      ls_q      <= LS_LB;
      pr_q      <= '0;
      rob_q     <= '0;
      result_q  <= '0;
      out_pr_q  <= '0;
      out_rob_q <= '0;
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      ls_q      <= ls_d;
      pr_q      <= pr_d;
      rob_q     <= rob_d;
      result_q  <= result_d;
      out_pr_q  <= out_pr_d;
      out_rob_q <= out_rob_d;
    end
  end

  // Outputs decoded from state; result fields persist after valid drops
  always_comb begin
    bus.rsb_fu_ready          = (state_q == S_IDLE);
    bus.fum_complete_req      = (state_q == S_DONE);
    bus.ld_cache_read_enable  = (state_q == S_MEM);
    bus.addr                  = (state_q == S_MEM) ? {ea_q[31:2], 2'b00} : 32'd0;
    bus.ld_sq_request         = '0;
    bus.ld_sq_request.valid   = (state_q == S_MEM);
    bus.ld_sq_request.addr    = bus.addr;
    bus.bs_out_pkt            = '0;
    bus.bs_out_pkt.valid      = (state_q == S_DONE);
    bus.bs_out_pkt.dest_value = result_q;
    bus.bs_out_pkt.dest_pr    = out_pr_q;
    bus.bs_out_pkt.rob_entry  = out_rob_q;
  end

endmodule

// File: tb/tb_fu_load.sv
// tb/tb_fu_load.sv - randomized scoreboard bench for fu_load
module tb_fu_load;
  import sys_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_load_if bus();

  fu_load u_dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {
    logic [31:0] v;
    logic [5:0]  pr;
    logic [4:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  LS_TYPE ls_tab[5] = '{LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU};

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: byte-wise forwarding merge, then arithmetic extraction
  function automatic logic [31:0] ref_load(input LS_TYPE ls, input logic [31:0] ea,
                                           input logic [31:0] cword, input logic [3:0] ub,
                                           input logic [31:0] sqd);
    logic [31:0] w;
    int unsigned b, h;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ub[i] ? sqd[8*i +: 8] : cword[8*i +: 8];
    b = (w >> (8 * ea[1:0])) & 32'hFF;
    h = (w >> (16 * ea[1])) & 32'hFFFF;
    case (ls)
      LS_LB:   return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      LS_LBU:  return 32'(b);
      LS_LH:   return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      LS_LHU:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic clear_mem_inputs();
    bus.ld_sq_response          = '0;
    bus.exs_dcache_hit_flags    = 1'b0;
    bus.broadcast_en            = 1'b0;
    bus.ld_cache_data_in        = $urandom;
    bus.exs_dcache_brdcast_data = $urandom;
  endtask

  task automatic issue(input LS_TYPE ls, input logic [31:0] r1, input logic [11:0] imm,
                       output logic [31:0] ea);
    int t = 0;
    while (!bus.rsb_fu_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t == 50) chk("ready_timeout", 0, 1);
    bus.bs_in_pkt.valid                  = 1'b1;
    bus.bs_in_pkt.inst                   = {imm, 5'($urandom), 3'b010, 5'($urandom), 7'b0000011};
    bus.bs_in_pkt.r1_value               = r1;
    bus.bs_in_pkt.dec_fu_opcode.ls       = ls;
    bus.bs_in_pkt.dispatch_allocated_prs = 6'($urandom);
    bus.bs_in_pkt.rob_entry              = 5'($urandom);
    ea = r1 + {{20{imm[11]}}, imm};
  endtask

  task automatic do_load(input LS_TYPE ls, input logic [31:0] r1, input logic [11:0] imm,
                         input logic [31:0] cword, input bit use_hit, input logic [3:0] ub,
                         input logic [31:0] sqd, input int stall_n, input int idle_n,
                         input int haz_n);
    logic [31:0] ea, expv;
    exp_t e;
    issue(ls, r1, imm, ea);
    expv  = ref_load(ls, ea, cword, ub, sqd);
    e.v   = expv;
    e.pr  = bus.bs_in_pkt.dispatch_allocated_prs;
    e.rob = bus.bs_in_pkt.rob_entry;
    sb.push_back(e);
    @(posedge clk); #1;
    // garbage issue during MEM must be ignored
    bus.bs_in_pkt = {1'b1, 31'($urandom), 32'($urandom), 32'($urandom), 14'($urandom)};
    chk("mem_read_en", bus.ld_cache_read_enable, 1);
    chk("mem_addr", bus.addr, {ea[31:2], 2'b00});
    chk("mem_sq_req", bus.ld_sq_request, {1'b1, ea[31:2], 2'b00});
    chk("mem_ready", bus.rsb_fu_ready, 0);
    for (int i = 0; i < idle_n; i++) begin
      bus.ld_sq_response = '{stall: 1'($urandom), usebytes: 4'($urandom_range(0, 14)), data: $urandom};
      bus.exs_dcache_hit_flags = 1'b0;
      bus.broadcast_en = 1'b0;
      @(posedge clk); #1;
      chk("nodata_req", bus.fum_complete_req, 0);
      chk("nodata_read_en", bus.ld_cache_read_enable, 1);
    end
    bus.ld_sq_response.usebytes = ub;
    bus.ld_sq_response.data     = sqd;
    if (use_hit) begin
      bus.exs_dcache_hit_flags    = 1'b1;
      bus.ld_cache_data_in        = cword;
      bus.broadcast_en            = 1'($urandom);
      bus.exs_dcache_brdcast_data = ~cword;
    end else if (ub != 4'hF) begin
      bus.exs_dcache_hit_flags    = 1'b0;
      bus.ld_cache_data_in        = ~cword;
      bus.broadcast_en            = 1'b1;
      bus.exs_dcache_brdcast_data = cword;
    end else begin
      bus.exs_dcache_hit_flags = 1'b0;
      bus.broadcast_en         = 1'b0;
    end
    for (int i = 0; i < stall_n; i++) begin
      bus.ld_sq_response.stall = 1'b1;
      @(posedge clk); #1;
      chk("stall_req", bus.fum_complete_req, 0);
    end
    bus.ld_sq_response.stall = 1'b0;
    @(posedge clk); #1;
    bus.bs_in_pkt.valid = 1'b0;
    clear_mem_inputs();
    bus.exs_dcache_hit_flags = 1'($urandom);
    chk("done_req", bus.fum_complete_req, 1);
    chk("done_read_en", bus.ld_cache_read_enable, 0);
    bus.bs_hazard = (haz_n > 0);
    for (int i = 0; i < haz_n; i++) begin
      @(posedge clk); #1;
      if (i == haz_n - 1) bus.bs_hazard = 1'b0;
      chk("haz_req", bus.fum_complete_req, 1);
      chk("haz_valid", bus.bs_out_pkt.valid, 1);
      chk("haz_ready", bus.rsb_fu_ready, 0);
    end
    @(posedge clk); #1;
    bus.exs_dcache_hit_flags = 1'b0;
    chk("post_valid", bus.bs_out_pkt.valid, 0);
    chk("post_req", bus.fum_complete_req, 0);
    chk("post_ready", bus.rsb_fu_ready, 1);
    chk("post_held_value", bus.bs_out_pkt.dest_value, expv);
  endtask

  // Monitor: every accepted completion pops the oldest expected result
  always @(negedge clk) begin
    if (!rst && bus.bs_out_pkt.valid && !bus.bs_hazard) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dest_value", bus.bs_out_pkt.dest_value, e.v);
        chk("dest_pr", bus.bs_out_pkt.dest_pr, e.pr);
        chk("rob_entry", bus.bs_out_pkt.rob_entry, e.rob);
        chk("other_fields", {bus.bs_out_pkt.take_branch, bus.bs_out_pkt.target_pc}, 0);
        chk("req_eq_valid", bus.fum_complete_req, 1);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.rsb_fu_ready, 1);
    chk({tag, "_req"}, bus.fum_complete_req, 0);
    chk({tag, "_out_pkt"}, bus.bs_out_pkt, 0);
    chk({tag, "_sq_req"}, bus.ld_sq_request, 0);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_read_en"}, bus.ld_cache_read_enable, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea;
    bus.bs_hazard = 1'b0;
    bus.bs_in_pkt = '0;
    clear_mem_inputs();
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed plan
    do_load(LS_LB,  32'h10000000, 12'd0, 32'h11223344, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LH,  32'h10000004, 12'd0, 32'h00007F00, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LW,  32'h10000008, 12'd0, 32'hDEADBEEF, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LBU, 32'h1000000C, 12'd0, 32'hFF223344, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LHU, 32'h10000010, 12'd0, 32'h0000ABCD, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LB,  32'h10000010, 12'd3, 32'h80000000, 1, 4'h0, 32'h0, 0, 0, 0);
    do_load(LS_LW,  32'h10000020, 12'd0, 32'h0,        0, 4'hF, 32'hCAFEF00D, 0, 0, 0);
    do_load(LS_LW,  32'h10000024, 12'd0, 32'h11223344, 1, 4'h1, 32'h000000AA, 0, 0, 0);
    do_load(LS_LW,  32'h10000028, 12'd0, 32'h12345678, 0, 4'h0, 32'h0, 3, 2, 0);
    do_load(LS_LW,  32'h1000002C, 12'hFFC, 32'h55AA55AA, 1, 4'h0, 32'h0, 0, 0, 2);

    // reset while in MEM
    issue(LS_LW, 32'h10000030, 12'd0, ea);
    @(posedge clk); #1;
    bus.bs_in_pkt.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midmem");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mem_inputs();
    do_load(LS_LHU, 32'h10000032, 12'd0, 32'h9ABC1234, 1, 4'h0, 32'h0, 0, 0, 0);

    // randomized loads
    for (int n = 0; n < 60; n++) begin
      logic [3:0] ub;
      ub = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      do_load(ls_tab[$urandom_range(0, 4)], $urandom, 12'($urandom), $urandom,
              1'($urandom), ub, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
